// File: rtl/mem_rsp_gather.sv
`default_nettype none
// mem_rsp_gather: gathers split coalescer read beats per tag into one full-mask response (rev 1.0).
// Optional build macro MEM_RSP_GATHER_PERF_EN adds perf_beats / perf_merged counters.
module mem_rsp_gather #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int UUID_WIDTH = 0,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           trk_valid,
  input  logic [NUM_REQS-1:0]            trk_mask,
  input  logic [TAG_WIDTH-1:0]           trk_tag,
  output logic                           trk_ready,
  input  logic                           rsp_in_valid,
  input  logic [NUM_REQS-1:0]            rsp_in_mask,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] rsp_in_data,
  input  logic [TAG_WIDTH-1:0]           rsp_in_tag,
  output logic                           rsp_in_ready,
  output logic                           rsp_out_valid,
  output logic [NUM_REQS-1:0]            rsp_out_mask,
  output logic [NUM_REQS*DATA_WIDTH-1:0] rsp_out_data,
  output logic [TAG_WIDTH-1:0]           rsp_out_tag,
  input  logic                           rsp_out_ready
`ifdef MEM_RSP_GATHER_PERF_EN
  ,
  output logic [31:0]                    perf_beats,
  output logic [31:0]                    perf_merged
`endif
);

  localparam int c_ENTRIES   = 1 << IDX_WIDTH;
  localparam int c_DW        = NUM_REQS * DATA_WIDTH;
  localparam int c_TAG_LO_W  = TAG_WIDTH - UUID_WIDTH;

  logic [c_ENTRIES-1:0] r_busy;
  logic [NUM_REQS-1:0]  r_exp  [c_ENTRIES];
  logic [NUM_REQS-1:0]  r_rem  [c_ENTRIES];
  logic [c_DW-1:0]      r_data [c_ENTRIES];

  logic                 r_out_valid;
  logic [NUM_REQS-1:0]  r_out_mask;
  logic [c_DW-1:0]      r_out_data;
  logic [TAG_WIDTH-1:0] r_out_tag;

  logic [IDX_WIDTH-1:0] w_trk_idx;
  logic [IDX_WIDTH-1:0] w_in_idx;
  logic                 w_trk_fire;
  logic                 w_in_fire;
  logic                 w_beat_ok;
  logic                 w_final;
  logic [NUM_REQS-1:0]  w_eff_mask;
  logic [NUM_REQS-1:0]  w_rem_n;
  logic [c_DW-1:0]      w_merged;
  logic                 w_unused_trk_tag;

  assign w_trk_idx        = trk_tag[IDX_WIDTH-1:0];
  assign w_in_idx         = rsp_in_tag[IDX_WIDTH-1:0];
  assign w_unused_trk_tag = ^trk_tag[TAG_WIDTH-1:IDX_WIDTH];

  assign trk_ready    = ~r_busy[w_trk_idx];
  assign rsp_in_ready = ~r_out_valid | rsp_out_ready;

  assign w_trk_fire = trk_valid & trk_ready;
  assign w_in_fire  = rsp_in_valid & rsp_in_ready;
  // Beats to idle entries are dropped; stray lanes outside rem_mask are ignored.
  assign w_beat_ok  = w_in_fire & r_busy[w_in_idx];
  assign w_eff_mask = rsp_in_mask & r_rem[w_in_idx];
  assign w_rem_n    = r_rem[w_in_idx] & ~rsp_in_mask;
  assign w_final    = w_beat_ok & (w_rem_n == '0);

  generate
    for (genvar l = 0; l < NUM_REQS; l++) begin : g_lane
      assign w_merged[l*DATA_WIDTH +: DATA_WIDTH] = w_eff_mask[l]
          ? rsp_in_data[l*DATA_WIDTH +: DATA_WIDTH]
          : r_data[w_in_idx][l*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      if (w_trk_fire) r_busy[w_trk_idx] <= 1'b1;
      if (w_final)    r_busy[w_in_idx]  <= 1'b0;
    end
  end

  // Entry payload needs no reset: it is only read while busy is set.
  always_ff @(posedge clk) begin
    if (w_trk_fire) begin
      r_exp[w_trk_idx] <= trk_mask;
      r_rem[w_trk_idx] <= trk_mask;
    end
    if (w_beat_ok) begin
      r_rem[w_in_idx]  <= w_rem_n;
      r_data[w_in_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else if (w_final) begin
      r_out_valid <= 1'b1;
      r_out_mask  <= r_exp[w_in_idx];
      r_out_data  <= w_merged;
      r_out_tag   <= rsp_in_tag;
    end else if (rsp_out_ready) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end
  end

  assign rsp_out_valid = r_out_valid;
  assign rsp_out_mask  = r_out_mask;
  assign rsp_out_data  = r_out_data;
  assign rsp_out_tag   = r_out_tag;

`ifdef MEM_RSP_GATHER_PERF_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_merged;

  // A completion was multi-beat if lanes had already been consumed before this beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_beats  <= '0;
      r_perf_merged <= '0;
    end else begin
      if (w_in_fire) r_perf_beats <= r_perf_beats + 32'd1;
      if (w_final && (r_rem[w_in_idx] != r_exp[w_in_idx])) r_perf_merged <= r_perf_merged + 32'd1;
    end
  end

  assign perf_beats  = r_perf_beats;
  assign perf_merged = r_perf_merged;
`endif

  a_cfg_idx_fits: assert property (@(posedge clk) IDX_WIDTH <= c_TAG_LO_W);
  a_beat_busy: assert property (@(posedge clk) disable iff (!reset)
      w_in_fire |-> r_busy[w_in_idx]);
  a_beat_in_rem: assert property (@(posedge clk) disable iff (!reset)
      w_beat_ok |-> ((rsp_in_mask & ~r_rem[w_in_idx]) == '0));

endmodule
`default_nettype wire
